// File: rtl/aes_128_pkg.sv
// Shared AES-128 definitions: schedule constants, round-constant table,
// key-expander state encoding and the word-level key schedule helpers.
package aes_128_pkg;

    localparam int NK = 4;
    localparam int NB = 4;
    localparam int NR = 10;

    // Round constants, indexed by round number 1..10 (entry 0 is unused).
    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_e;

    // Looks up the round constant; indices outside 1..10 yield zero.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] rc;
        rc = 8'h00;
        for (int i = 1; i <= NR; i++) begin
            if (r == i[3:0]) begin
                rc = RCON[i];
            end
        end
        return rc;
    endfunction

    // Cyclic left rotation of a word by one byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Derives the next round key from the previous one. sub_word is
    // SubWord(RotWord(w3)) of the previous key, computed by the S-boxes.
    function automatic logic [127:0] round_key_next(input logic [127:0] prev,
                                                    input logic [31:0]  sub_word,
                                                    input logic [7:0]   rcon);
        logic [31:0] t;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        t  = sub_word ^ {rcon, 24'h000000};
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64]  ^ w0;
        w2 = prev[63:32]  ^ w1;
        w3 = prev[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational byte substitution.
// Also used by the SubBytes stage of the encryptor.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    // Byte 0x00 maps from the most significant byte of this constant.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX[{~in_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_128_key_expander.sv
// Iterative AES-128 key schedule. A key accepted over valid/ready is expanded
// into 11 round keys, one per cycle, held in a register file read by index.
// Optional macro AES_KEYEXP_STREAM_EN adds a registered round-key stream
// (one pulse per key as it is written) for a pipelined consumer.
module aes_128_key_expander
    import aes_128_pkg::*;
#(
    parameter int OUT_REG = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         keys_valid,
    output logic         busy
`ifdef AES_KEYEXP_STREAM_EN
    ,
    output logic         rk_strm_valid,
    output logic [3:0]   rk_strm_idx,
    output logic [127:0] rk_strm
`endif
);

    state_e       state_q;
    state_e       state_d;
    logic [3:0]   round_q;
    logic [3:0]   round_d;
    logic [127:0] last_rk_q;
    logic [127:0] store_q [0:10];
    logic         accept;
    logic [31:0]  rot_w;
    logic [31:0]  sub_w;
    logic [127:0] next_rk;
    logic [127:0] rd_data;

    assign key_ready  = (state_q != EXPAND);
    assign busy       = (state_q == EXPAND);
    assign keys_valid = (state_q == READY);
    assign accept     = key_valid && key_ready;

    // The most recently written key is kept separately so the next round
    // key never needs a wide read mux on the store.
    assign rot_w = rot_word(last_rk_q[31:0]);

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .in_i  (rot_w[8*b +: 8]),
            .out_o (sub_w[8*b +: 8])
        );
    end

    assign next_rk = round_key_next(last_rk_q, sub_w, rcon_of(round_q));

    // Next-state logic: accept from IDLE/READY, count rounds 1..10 in EXPAND.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            IDLE, READY: begin
                if (accept) begin
                    state_d = EXPAND;
                    round_d = 4'd1;
                end
            end
            EXPAND: begin
                if (round_q == 4'(NR)) begin
                    state_d = READY;
                    round_d = 4'd0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = 4'd0;
            end
        endcase
    end

    // State, round counter and the last-written round key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            round_q   <= 4'd0;
            last_rk_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            if (accept) begin
                last_rk_q <= key;
            end else if (state_q == EXPAND) begin
                last_rk_q <= next_rk;
            end
        end
    end

    // Round-key store: slot 0 on accept, slot[round] during expansion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) begin
                store_q[i] <= '0;
            end
        end else if (accept) begin
            store_q[0] <= key;
        end else if (state_q == EXPAND) begin
            for (int i = 1; i <= NR; i++) begin
                if (round_q == i[3:0]) begin
                    store_q[i] <= next_rk;
                end
            end
        end
    end

    // Read port: only a completed schedule is visible, out-of-range reads give zero.
    always_comb begin
        rd_data = '0;
        if (keys_valid) begin
            for (int i = 0; i <= NR; i++) begin
                if (rk_idx == i[3:0]) begin
                    rd_data = store_q[i];
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [127:0] rk_out_q;

        // Registered read: rk_out follows rk_idx with one cycle of latency.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rk_out_q <= '0;
            end else begin
                rk_out_q <= rd_data;
            end
        end

        assign rk_out = rk_out_q;
    end else begin : g_out_comb
        assign rk_out = rd_data;
    end

`ifdef AES_KEYEXP_STREAM_EN
    logic         strm_valid_q;
    logic [3:0]   strm_idx_q;
    logic [127:0] strm_q;

    // Stream each round key as it is written: key 0 on accept, then 1..10.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strm_valid_q <= 1'b0;
            strm_idx_q   <= 4'd0;
            strm_q       <= '0;
        end else if (accept) begin
            strm_valid_q <= 1'b1;
            strm_idx_q   <= 4'd0;
            strm_q       <= key;
        end else if (state_q == EXPAND) begin
            strm_valid_q <= 1'b1;
            strm_idx_q   <= round_q;
            strm_q       <= next_rk;
        end else begin
            strm_valid_q <= 1'b0;
            strm_idx_q   <= 4'd0;
            strm_q       <= '0;
        end
    end

    assign rk_strm_valid = strm_valid_q;
    assign rk_strm_idx   = strm_idx_q;
    assign rk_strm       = strm_q;
`endif

endmodule

// File: tb/tb_aes_128_key_expander.sv
// Testbench for aes_128_key_expander: FIPS-197 vectors plus random keys,
// checked against a word-level key schedule model with its own S-box.
// Covers both read-port variants (OUT_REG=0 and OUT_REG=1) side by side.
module tb_aes_128_key_expander;

    logic         clk;
    logic         rst_n;
    logic         keyValid;
    logic [127:0] keyIn;
    logic [3:0]   rkIdx;
    logic         keyReady;
    logic [127:0] rkOut;
    logic         keysValid;
    logic         busy;
    logic         regKeyReady;
    logic [127:0] regRkOut;
    logic         regKeysValid;
    logic         regBusy;

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0]   sboxModel [0:255];
    logic [127:0] modelRk [0:10];
    logic         modelValid;

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

`ifdef AES_KEYEXP_STREAM_EN
    logic         strmValid;
    logic [3:0]   strmIdx;
    logic [127:0] strmData;
    logic         regStrmValid;
    logic [3:0]   regStrmIdx;
    logic [127:0] regStrmData;
    int           strmNext = 0;
`endif

    aes_128_key_expander #(.OUT_REG(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (keyValid),
        .key_ready  (keyReady),
        .key        (keyIn),
        .rk_idx     (rkIdx),
        .rk_out     (rkOut),
        .keys_valid (keysValid),
        .busy       (busy)
`ifdef AES_KEYEXP_STREAM_EN
        ,
        .rk_strm_valid (strmValid),
        .rk_strm_idx   (strmIdx),
        .rk_strm       (strmData)
`endif
    );

    aes_128_key_expander #(.OUT_REG(1)) dutReg (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (keyValid),
        .key_ready  (regKeyReady),
        .key        (keyIn),
        .rk_idx     (rkIdx),
        .rk_out     (regRkOut),
        .keys_valid (regKeysValid),
        .busy       (regBusy)
`ifdef AES_KEYEXP_STREAM_EN
        ,
        .rk_strm_valid (regStrmValid),
        .rk_strm_idx   (regStrmIdx),
        .rk_strm       (regStrmData)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            end
            sboxModel[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                           ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Word-array key expansion with round constants generated by doubling.
    task automatic computeModel(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sboxModel[t[31:24]], sboxModel[t[23:16]],
                     sboxModel[t[15:8]], sboxModel[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) begin
            modelRk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [127:0] expectedRead(input int idx);
        if (modelValid && idx <= 10) return modelRk[idx];
        return '0;
    endfunction

`ifdef AES_KEYEXP_STREAM_EN
    // Stream monitor: every pulse must carry the next index and its model key.
    always @(negedge clk) begin
        if (strmValid) begin
            checkOutput("strm_idx", {124'd0, strmIdx}, 128'(strmNext));
            checkOutput("strm_data", strmData, modelRk[strmNext % 11]);
            checkOutput("strm_reg_data", regStrmData, strmData);
            strmNext++;
        end
    end
`endif

    // Presents a key for one accept edge (optionally holding a different key
    // afterwards) and waits, with a bound, for the schedule to complete.
    task automatic applyStimulus(input logic [127:0] k, input bit holdOther,
                                 input logic [127:0] otherKey);
        int cycles;
        computeModel(k);
`ifdef AES_KEYEXP_STREAM_EN
        strmNext = 0;
`endif
        keyIn    = k;
        keyValid = 1'b1;
        @(posedge clk);
        #1;
        modelValid = 1'b0;
        checkOutput("accept_keys_valid", {127'd0, keysValid}, 128'd0);
        checkOutput("accept_busy", {127'd0, busy}, 128'd1);
        checkOutput("accept_ready", {127'd0, keyReady}, 128'd0);
        if (holdOther) begin
            keyIn = otherKey;
        end else begin
            keyValid = 1'b0;
        end
        cycles = 0;
        while (!keysValid && cycles < 20) begin
            if (holdOther) begin
                checkOutput("hold_ready", {127'd0, keyReady}, 128'd0);
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        keyValid = 1'b0;
        checkOutput("latency", 128'(cycles), 128'd10);
        checkOutput("done_busy", {127'd0, busy}, 128'd0);
        checkOutput("done_ready", {127'd0, keyReady}, 128'd1);
        checkOutput("reg_keys_valid", {127'd0, regKeysValid}, {127'd0, keysValid});
        modelValid = 1'b1;
`ifdef AES_KEYEXP_STREAM_EN
        checkOutput("strm_count", 128'(strmNext), 128'd11);
`endif
    endtask

    // Sweeps every index through both read ports.
    task automatic readAll();
        for (int i = 0; i < 16; i++) begin
            rkIdx = i[3:0];
            @(negedge clk);
            checkOutput($sformatf("rk_out[%0d]", i), rkOut, expectedRead(i));
            @(posedge clk);
            #1;
            checkOutput($sformatf("reg_rk_out[%0d]", i), regRkOut, expectedRead(i));
        end
    endtask

    task automatic readOne(input int idx, input string tag, input logic [127:0] expected);
        rkIdx = idx[3:0];
        @(negedge clk);
        checkOutput(tag, rkOut, expected);
    endtask

    initial begin
        rst_n      = 1'b0;
        keyValid   = 1'b0;
        keyIn      = '0;
        rkIdx      = 4'd0;
        modelValid = 1'b0;
        buildSbox();

        #12;
        checkOutput("reset_ready", {127'd0, keyReady}, 128'd1);
        checkOutput("reset_keys_valid", {127'd0, keysValid}, 128'd0);
        checkOutput("reset_busy", {127'd0, busy}, 128'd0);
        checkOutput("reset_rk_out", rkOut, 128'd0);
        checkOutput("reset_reg_rk_out", regRkOut, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // FIPS-197 A.1 key
        applyStimulus(KEY_A1, 1'b0, '0);
        readOne(1, "a1_rk1", A1_RK1);
        readOne(10, "a1_rk10", A1_RK10);
        readAll();

        // New key while READY: the all-zero key
        applyStimulus('0, 1'b0, '0);
        readOne(1, "zero_rk1", ZERO_RK1);
        readOne(10, "zero_rk10", ZERO_RK10);
        readOne(11, "zero_idx11", 128'd0);
        readAll();

        // key_valid held through EXPAND with a different key: ignored
        applyStimulus(KEY_A1, 1'b1, 128'hdeadbeef_01234567_89abcdef_cafef00d);
        @(posedge clk);
        #1;
        checkOutput("hold_not_requeued", {127'd0, busy}, 128'd0);
        readOne(10, "hold_rk10", A1_RK10);
        readAll();

        // Reset in the middle of an expansion
        computeModel(128'h000102030405060708090a0b0c0d0e0f);
        keyIn    = 128'h000102030405060708090a0b0c0d0e0f;
        keyValid = 1'b1;
        @(posedge clk);
        #1;
        keyValid   = 1'b0;
        modelValid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_keys_valid", {127'd0, keysValid}, 128'd0);
        checkOutput("midreset_busy", {127'd0, busy}, 128'd0);
        checkOutput("midreset_ready", {127'd0, keyReady}, 128'd1);
        checkOutput("midreset_rk_out", rkOut, 128'd0);
        checkOutput("midreset_reg_rk_out", regRkOut, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        readOne(0, "post_reset_rk0", 128'd0);
        applyStimulus(KEY_A1, 1'b0, '0);
        readOne(1, "reload_rk1", A1_RK1);
        readOne(10, "reload_rk10", A1_RK10);

        // Random keys
        for (int n = 0; n < 4; n++) begin
            applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
            readAll();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
